// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: default sizes and FSM encoding.
package imem_arbiter_pkg;

  localparam int unsigned WORD_SIZE_DEF = 32;
  localparam int unsigned ADDR_SIZE_DEF = 10;
  localparam int unsigned MAX_WAIT_DEF  = 4;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StProg  = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
);

  logic                 f_req;
  logic [ADDR_SIZE-1:0] f_addr;
  logic                 f_gnt;
  logic                 f_rvalid;
  logic [WORD_SIZE-1:0] f_rdata;

  logic                 l_req;
  logic                 l_we;
  logic [ADDR_SIZE-1:0] l_addr;
  logic [WORD_SIZE-1:0] l_wdata;
  logic                 l_gnt;
  logic                 l_rvalid;
  logic [WORD_SIZE-1:0] l_rdata;

  logic                 prog_mode;

  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  logic                 fetch_stall;
  logic                 fetch_flush;

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, prog_mode, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
    output mem_addr, mem_we, mem_wdata, fetch_stall, fetch_flush
  );

  // Requester / memory side.
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, prog_mode, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
    input  mem_addr, mem_we, mem_wdata, fetch_stall, fetch_flush
  );

endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port instruction memory between the fetch unit and a program loader,
// with an exclusive programming mode and bounded fetch starvation in shared mode.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEF
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  arb_state_e           state_q, state_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic                 pend_q, pend_d;
  logic                 owner_q, owner_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;

  logic f_gnt_c, l_gnt_c, stall_c, flush_c;
  logic f_gnt, l_gnt;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    f_gnt_c = 1'b0;
    l_gnt_c = 1'b0;
    stall_c = 1'b0;
    flush_c = 1'b0;
    unique case (state_q)
      StRun: begin
        // Loader wins unless fetch has already been starved for MAX_WAIT cycles.
        if (bus.l_req && !(bus.f_req && wait_q == WaitMax)) begin
          l_gnt_c = 1'b1;
        end else if (bus.f_req) begin
          f_gnt_c = 1'b1;
        end
        stall_c = bus.f_req & ~f_gnt_c;
        if (bus.f_req && !f_gnt_c) begin
          wait_d = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);
        end
        if (bus.prog_mode) state_d = StProg;
      end
      StProg: begin
        l_gnt_c = bus.l_req;
        stall_c = 1'b1;
        if (!bus.prog_mode) state_d = StDrain;
      end
      StDrain: begin
        stall_c = 1'b1;
        flush_c = 1'b1;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs are forced quiet while reset is held, even if requests are present.
  assign f_gnt = rst & f_gnt_c;
  assign l_gnt = rst & l_gnt_c;

  assign bus.f_gnt       = f_gnt;
  assign bus.l_gnt       = l_gnt;
  assign bus.fetch_stall = rst & stall_c;
  assign bus.fetch_flush = rst & flush_c;

  assign bus.mem_we    = l_gnt & bus.l_we;
  assign bus.mem_addr  = l_gnt ? bus.l_addr : (f_gnt ? bus.f_addr : addr_q);
  assign bus.mem_wdata = l_gnt ? bus.l_wdata : wdata_q;

  assign pend_d  = f_gnt | (l_gnt & ~bus.l_we);
  assign owner_d = l_gnt;

  assign bus.f_rvalid = pend_q & ~owner_q;
  assign bus.l_rvalid = pend_q & owner_q;
  assign bus.f_rdata  = bus.f_rvalid ? bus.mem_rdata : '0;
  assign bus.l_rdata  = bus.l_rvalid ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
      addr_q  <= bus.mem_addr;
      wdata_q <= bus.mem_wdata;
    end
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, 32, data width; ADDR_SIZE, 10, byte-address width; MAX_WAIT, 4, max consecutive cycles fetch may be denied in RUN.
REQ-002 Ports SHALL be:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-low reset.
- f_req, input, 1, fetch read request.
- f_addr, input, ADDR_SIZE, fetch address.
- f_gnt, output, 1, fetch request accepted this cycle.
- f_rvalid, output, 1, fetch read data valid.
- f_rdata, output, WORD_SIZE, fetch read data.
- l_req, input, 1, loader request.
- l_we, input, 1, loader write (1) or read (0).
- l_addr, input, ADDR_SIZE, loader address.
- l_wdata, input, WORD_SIZE, loader write data.
- l_gnt, output, 1, loader request accepted this cycle.
- l_rvalid, output, 1, loader read data valid.
- l_rdata, output, WORD_SIZE, loader read data.
- prog_mode, input, 1, loader requests exclusive memory ownership.
- mem_addr, output, ADDR_SIZE, memory address.
- mem_we, output, 1, memory write enable.
- mem_wdata, output, WORD_SIZE, memory write data.
- mem_rdata, input, WORD_SIZE, memory read data, one-cycle synchronous latency.
- fetch_stall, output, 1, drives the PC register enable low when 1.
- fetch_flush, output, 1, one-cycle pulse requesting an IF/ID flush and refetch.

Function
REQ-003 At most one requester SHALL be granted per cycle; a grant means that request's addr, we and wdata are driven onto the mem_* signals combinationally in the same cycle.
REQ-004 The FSM SHALL have three states:
- RUN: shared access.
- PROG: loader exclusive.
- DRAIN: leaving PROG.
REQ-005 RUN -> PROG SHALL occur when prog_mode=1; PROG -> DRAIN when prog_mode=0; DRAIN -> RUN after exactly one cycle.
REQ-006 In RUN, loader SHALL have priority over fetch unless the wait counter equals MAX_WAIT, in which case fetch SHALL be granted.
REQ-007 The wait counter SHALL increment, saturating at MAX_WAIT, each RUN cycle with f_req=1 and f_gnt=0; it SHALL clear on f_gnt=1 or f_req=0.
REQ-008 In PROG and DRAIN, f_gnt SHALL be 0 and fetch_stall SHALL be 1; loader grants SHALL be unconditional in PROG and SHALL be 0 in DRAIN.
REQ-009 In RUN, fetch_stall SHALL equal f_req & ~f_gnt.
REQ-010 fetch_flush SHALL be 1 for exactly the DRAIN cycle.
REQ-011 Each granted read SHALL register a 1-bit owner tag; the next cycle SHALL assert exactly one of f_rvalid/l_rvalid per that tag, with *_rdata=mem_rdata; writes produce no rvalid.
REQ-012 When no request is granted, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their previous values.
REQ-013 A read granted in the last RUN cycle before PROG SHALL still return its rvalid in the first PROG cycle.
REQ-014 If prog_mode rises while a RUN arbitration is in progress, the grant already issued in that cycle SHALL complete; new fetch grants SHALL stop from the next cycle.

Reset
REQ-015 While rst=0, the block SHALL hold:
- state RUN; wait counter 0; owner tag and pending-read flag cleared.
- f_gnt, l_gnt, f_rvalid, l_rvalid, mem_we, fetch_flush all 0.
- fetch_stall, mem_addr, mem_wdata, f_rdata, l_rdata all 0.
REQ-016 Reset mid-transaction SHALL discard the pending read, so no rvalid is produced after deassertion.

Structure
REQ-017 The FSM state encoding and the default WORD_SIZE/ADDR_SIZE/MAX_WAIT values SHALL live in the shared core package.
REQ-018 The block SHALL be a single module with no sub-modules.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then f_req=1, f_addr=0x010, l_req=0 -> f_gnt=1 same cycle; next cycle f_rvalid=1, f_rdata=mem[0x010].
- f_req=1 and l_req=1 held continuously in RUN -> l_gnt for 4 cycles, f_gnt on the 5th, then loader resumes; fetch_stall=1 exactly during the 4 denied cycles.
- prog_mode=1, then l_we=1 writes 0xDEADBEEF to 0x020 -> fetch_stall=1 and f_gnt=0 throughout; on prog_mode=0, one DRAIN cycle with fetch_flush=1, then a fetch of 0x020 returns 0xDEADBEEF.
- Fetch read granted, prog_mode=1 the same cycle -> f_rvalid=1 next cycle (PROG), with no further f_gnt.
- Loader read granted, rst=0 asserted the following cycle before rvalid -> l_rvalid stays 0 through reset and after release.
- No requests for 10 cycles -> mem_we=0, and every gnt/rvalid output stays 0.
